// File: rtl/store_buffer_pkg.sv
// ============================================================================
//  Module   : store_buffer_pkg
//  Purpose  : Shared definitions for the store buffer: memory access length
//             encodings, a bytes-of-length helper (also used by the data
//             memory and the MEM stage) and the load-data extension helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_buffer_pkg;

  // Access length encodings shared by the MEM stage, store buffer and memory
  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  // Number of bytes touched by an access of the given length (0..4)
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_BYTE: n = 3'd1;
      LEN_HALF: n = 3'd2;
      LEN_WORD: n = 3'd4;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

  // Select the low bytes of a buffered word for a forwarded load and extend
  // them to 32 bits; word loads pass the full word untouched.
  function automatic logic [31:0] load_extend(input logic [31:0] data,
                                              input logic [1:0]  len,
                                              input logic        sign);
    logic [31:0] r;
    case (len)
      LEN_BYTE: r = {{24{sign & data[7]}},  data[7:0]};
      LEN_HALF: r = {{16{sign & data[15]}}, data[15:0]};
      default:  r = data;
    endcase
    return r;
  endfunction

endpackage : store_buffer_pkg

`default_nettype wire

// File: rtl/store_buffer_sb_range_overlap.sv
// ============================================================================
//  Module   : sb_range_overlap
//  Purpose  : Compares one buffered store's byte range against a load's byte
//             range. Reports whether they intersect and whether the store
//             starts at the load address and covers every byte of the load.
//  Ports    : entry_address/entry_length - buffered store range
//             load_address/load_length   - load range
//             overlap                    - ranges share at least one byte
//             exact_cover                - same start, store at least as wide
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_range_overlap
  import store_buffer_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] entry_address,
  input  logic [1:0]    entry_length,
  input  logic [AW-1:0] load_address,
  input  logic [1:0]    load_length,
  output logic          overlap,
  output logic          exact_cover
);

  // Ranges are half-open [start, end). Two spare bits keep an access that
  // ends exactly at the top of memory from wrapping back to address zero.
  logic [AW+1:0] entry_start;
  logic [AW+1:0] entry_end;
  logic [AW+1:0] load_start;
  logic [AW+1:0] load_end;
  logic [2:0]    entry_bytes;
  logic [2:0]    load_bytes;

  assign entry_bytes = len_bytes(entry_length);
  assign load_bytes  = len_bytes(load_length);

  assign entry_start = {2'b00, entry_address};
  assign load_start  = {2'b00, load_address};
  assign entry_end   = entry_start + {{(AW-1){1'b0}}, entry_bytes};
  assign load_end    = load_start  + {{(AW-1){1'b0}}, load_bytes};

  // A zero-length access touches nothing and can never intersect.
  assign overlap = (entry_bytes != 3'd0) && (load_bytes != 3'd0) &&
                   (entry_start < load_end) && (load_start < entry_end);

  assign exact_cover = (load_bytes != 3'd0) &&
                       (entry_address == load_address) &&
                       (entry_bytes >= load_bytes);

endmodule : sb_range_overlap

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
//  Module   : store_buffer
//  Purpose  : In-order store buffer between the MEM stage and the data memory
//             write port. Committed stores are queued and drained one per
//             cycle; loads are checked against every buffered store and are
//             either forwarded (exact cover by the youngest overlapping
//             store) or stalled (any other overlap).
//  Ports    : SYS_clk, SYS_reset (sync, active-low)
//             ST_*   - store request in, ST_ready back-pressure
//             SB_drain_en - 0 holds the queue, SB_empty - queue empty
//             LD_*   - load probe in, forward hit/data and stall out
//             MEM_write_* - data memory write port (length 00 = idle)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          SYS_clk,
  input  logic          SYS_reset,
  // store side
  input  logic          ST_valid,
  output logic          ST_ready,
  input  logic [AW-1:0] ST_address,
  input  logic [31:0]   ST_data,
  input  logic [1:0]    ST_length,
  // drain control / status
  input  logic          SB_drain_en,
  output logic          SB_empty,
  // load probe
  input  logic          LD_valid,
  input  logic [AW-1:0] LD_address,
  input  logic [1:0]    LD_length,
  input  logic          LD_signed,
  output logic          LD_forward_hit,
  output logic [31:0]   LD_forward_data,
  output logic          LD_stall,
  // data memory write port
  output logic [1:0]    MEM_write_length,
  output logic [AW-1:0] MEM_write_address,
  output logic [31:0]   MEM_write_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_COUNT = CW'(DEPTH);

  // --------------------------------------------------------------------------
  // Entry storage and queue bookkeeping
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0] ent_valid;
  logic [AW-1:0]    ent_address [DEPTH];
  logic [31:0]      ent_data    [DEPTH];
  logic [1:0]       ent_length  [DEPTH];

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic             not_full;
  logic             push;
  logic             pop;

  assign not_full = (count < DEPTH_COUNT);

  // The full check uses the pre-pop count: a slot freed by this cycle's pop
  // only becomes available next cycle. Zero-length stores are accepted and
  // silently dropped.
  assign push = SYS_reset & ST_valid & not_full & (ST_length != LEN_NONE);
  assign pop  = SYS_reset & SB_drain_en & (count != '0);

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        ent_valid[tail]   <= 1'b1;
        ent_address[tail] <= ST_address;
        ent_data[tail]    <= ST_data;
        ent_length[tail]  <= ST_length;
        tail              <= tail + 1'b1;
      end
      // With count in (0, DEPTH) head and tail differ, so a same-cycle push
      // and pop never touch the same slot.
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Store-side status and memory write port
  // --------------------------------------------------------------------------
  assign ST_ready          = SYS_reset & not_full;
  assign SB_empty          = ~SYS_reset | (count == '0);
  assign MEM_write_length  = pop ? ent_length[head] : LEN_NONE;
  assign MEM_write_address = ent_address[head];
  assign MEM_write_data    = ent_data[head];

  // --------------------------------------------------------------------------
  // Per-entry overlap detection against the load
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0] ent_overlap;
  logic [DEPTH-1:0] ent_cover;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_overlap
      sb_range_overlap #(
        .AW (AW)
      ) u_overlap (
        .entry_address (ent_address[i]),
        .entry_length  (ent_length[i]),
        .load_address  (LD_address),
        .load_length   (LD_length),
        .overlap       (ent_overlap[i]),
        .exact_cover   (ent_cover[i])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Youngest overlapping entry: walk backwards from the slot just before tail
  // and take the first live entry that overlaps. Only that entry decides
  // between forward and stall, so an older partial overlap hidden behind a
  // younger exact cover does not stall the load.
  // --------------------------------------------------------------------------
  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] scan_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = tail - PW'(k + 1);
      if (!pick_found && ent_valid[scan_idx] && ent_overlap[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  logic load_conflict;

  assign load_conflict   = SYS_reset & LD_valid & pick_found;
  assign LD_forward_hit  = load_conflict &  ent_cover[pick_idx];
  assign LD_stall        = load_conflict & ~ent_cover[pick_idx];
  assign LD_forward_data = LD_forward_hit ?
                           load_extend(ent_data[pick_idx], LD_length, LD_signed) :
                           32'h0000_0000;

endmodule : store_buffer

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Self-checking bench for store_buffer. A queue-based reference
//             model predicts every output each cycle; directed scenarios are
//             followed by a randomized phase.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_address;
  logic [31:0]   st_data;
  logic [1:0]    st_length;
  logic          drain_en;
  logic          sb_empty;
  logic          ld_valid;
  logic [AW-1:0] ld_address;
  logic [1:0]    ld_length;
  logic          ld_signed;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic          ld_stall;
  logic [1:0]    mw_length;
  logic [AW-1:0] mw_address;
  logic [31:0]   mw_data;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .SYS_clk           (clk),
    .SYS_reset         (rst_n),
    .ST_valid          (st_valid),
    .ST_ready          (st_ready),
    .ST_address        (st_address),
    .ST_data           (st_data),
    .ST_length         (st_length),
    .SB_drain_en       (drain_en),
    .SB_empty          (sb_empty),
    .LD_valid          (ld_valid),
    .LD_address        (ld_address),
    .LD_length         (ld_length),
    .LD_signed         (ld_signed),
    .LD_forward_hit    (fwd_hit),
    .LD_forward_data   (fwd_data),
    .LD_stall          (ld_stall),
    .MEM_write_length  (mw_length),
    .MEM_write_address (mw_address),
    .MEM_write_data    (mw_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  len;
  } store_t;

  store_t q[$];
  int checks    = 0;
  int errors    = 0;
  int stall_run = 0;

  function automatic int nbytes(input logic [1:0] l);
    case (l)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Predict all outputs from the queue contents and current inputs.
  task automatic check_model();
    int          n;
    bit          hit_e;
    bit          stall_e;
    logic [31:0] data_e;
    longint      es, ee, ls, le;
    logic [31:0] d;
    n       = q.size();
    hit_e   = 0;
    stall_e = 0;
    data_e  = 0;
    if (!rst_n) begin
      chk("rst_ready", {31'd0, st_ready}, 0);
      chk("rst_wlen", {30'd0, mw_length}, 0);
      chk("rst_hit", {31'd0, fwd_hit}, 0);
      chk("rst_stall", {31'd0, ld_stall}, 0);
      chk("rst_empty", {31'd0, sb_empty}, 1);
      stall_run = 0;
      return;
    end
    chk("ready", {31'd0, st_ready}, (n < DEPTH) ? 1 : 0);
    chk("empty", {31'd0, sb_empty}, (n == 0) ? 1 : 0);
    if (drain_en && n > 0) begin
      chk("wlen", {30'd0, mw_length}, {30'd0, q[0].len});
      chk("waddr", mw_address, q[0].addr);
      chk("wdata", mw_data, q[0].data);
    end else begin
      chk("wlen_idle", {30'd0, mw_length}, 0);
    end
    if (ld_valid && nbytes(ld_length) > 0) begin
      ls = longint'({32'd0, ld_address});
      le = ls + nbytes(ld_length);
      for (int j = n - 1; j >= 0; j--) begin
        es = longint'({32'd0, q[j].addr});
        ee = es + nbytes(q[j].len);
        if (es < le && ls < ee) begin
          if (q[j].addr == ld_address && nbytes(q[j].len) >= nbytes(ld_length)) begin
            hit_e = 1;
            d = q[j].data;
            if (nbytes(ld_length) == 1) begin
              data_e = d & 32'hFF;
              if (ld_signed && d[7]) data_e = data_e | 32'hFFFF_FF00;
            end else if (nbytes(ld_length) == 2) begin
              data_e = d & 32'hFFFF;
              if (ld_signed && d[15]) data_e = data_e | 32'hFFFF_0000;
            end else begin
              data_e = d;
            end
          end else begin
            stall_e = 1;
          end
          break;
        end
      end
    end
    chk("hit", {31'd0, fwd_hit}, {31'd0, hit_e});
    chk("stall", {31'd0, ld_stall}, {31'd0, stall_e});
    if (hit_e) chk("fwd_data", fwd_data, data_e);
    if (ld_stall && !drain_en) stall_run++;
    else stall_run = 0;
    if (stall_run > 0) chk("stall_bound", (stall_run <= DEPTH) ? 1 : 0, 1);
  endtask

  // Apply the edge effects of the current inputs to the model.
  task automatic model_edge();
    int n;
    n = q.size();
    if (!rst_n) begin
      q.delete();
    end else begin
      if (drain_en && n > 0) void'(q.pop_front());
      if (st_valid && n < DEPTH && st_length != 2'b00)
        q.push_back('{st_address, st_data, st_length});
    end
  endtask

  // Inputs already driven at posedge+1; check before the next edge.
  task automatic cycle();
    #2;
    check_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid   = 0;
    st_address = 0;
    st_data    = 0;
    st_length  = 0;
    ld_valid   = 0;
    ld_address = 0;
    ld_length  = 0;
    ld_signed  = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] l);
    st_valid   = 1;
    st_address = a;
    st_data    = d;
    st_length  = l;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] l, input logic s);
    ld_valid   = 1;
    ld_address = a;
    ld_length  = l;
    ld_signed  = s;
  endtask

  task automatic drain_all();
    idle();
    drain_en = 1;
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) cycle();
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC + $urandom_range(0, 3);
    return 32'h40 + $urandom_range(0, 15);
  endfunction

  initial begin
    idle();
    rst_n    = 0;
    drain_en = 1;
    cycle();
    cycle();

    // Single word store drains the following cycle
    rst_n = 1;
    store(32'h10, 32'hDEAD_BEEF, 2'b11);
    cycle();
    idle();
    #1;
    chk("t1_wlen", {30'd0, mw_length}, 32'd3);
    chk("t1_waddr", mw_address, 32'h10);
    chk("t1_wdata", mw_data, 32'hDEAD_BEEF);
    cycle();
    #1;
    chk("t1_empty", {31'd0, sb_empty}, 1);
    cycle();

    // Fill with draining held, then drain in order
    drain_en = 0;
    for (int i = 0; i < 5; i++) begin
      store(32'h100 + 4 * i, i + 1, 2'b11);
      if (i == 4) begin
        #1;
        chk("t2_full_ready", {31'd0, st_ready}, 0);
      end
      cycle();
    end
    idle();
    drain_en = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_order", mw_address, 32'h100 + 4 * i);
      cycle();
    end
    cycle();

    // Dropped zero-length store
    store(32'h50, 32'h1234, 2'b00);
    cycle();
    idle();
    #1;
    chk("t_drop_empty", {31'd0, sb_empty}, 1);
    cycle();

    // Forward signed / unsigned byte from a buffered word
    drain_en = 0;
    store(32'h20, 32'h8899_AABB, 2'b11);
    cycle();
    idle();
    load(32'h20, 2'b01, 1);
    #1;
    chk("t3_hit", {31'd0, fwd_hit}, 1);
    chk("t3_sdata", fwd_data, 32'hFFFF_FFBB);
    cycle();
    load(32'h20, 2'b01, 0);
    #1;
    chk("t3_udata", fwd_data, 32'h0000_00BB);
    cycle();
    drain_all();

    // Partial overlap stalls until the entry drains
    drain_en = 0;
    store(32'h21, 32'h55, 2'b01);
    cycle();
    idle();
    load(32'h20, 2'b11, 0);
    #1;
    chk("t4_stall", {31'd0, ld_stall}, 1);
    cycle();
    drain_en = 1;
    #1;
    chk("t4_stall_drain", {31'd0, ld_stall}, 1);
    cycle();
    #1;
    chk("t4_stall_clear", {31'd0, ld_stall}, 0);
    chk("t4_hit_clear", {31'd0, fwd_hit}, 0);
    cycle();
    drain_all();

    // Youngest of two same-address stores wins
    drain_en = 0;
    store(32'h30, 32'h1, 2'b11);
    cycle();
    store(32'h30, 32'h2, 2'b11);
    cycle();
    idle();
    load(32'h30, 2'b11, 0);
    #1;
    chk("t5_youngest", fwd_data, 32'h2);
    cycle();
    drain_all();

    // Top-of-memory: byte at the last address never aliases address 0
    drain_en = 0;
    store(32'hFFFF_FFFF, 32'h7F, 2'b01);
    cycle();
    idle();
    load(32'h0, 2'b11, 0);
    #1;
    chk("t_wrap_nostall", {31'd0, ld_stall}, 0);
    cycle();
    load(32'hFFFF_FFFE, 2'b10, 0);
    #1;
    chk("t_wrap_stall", {31'd0, ld_stall}, 1);
    cycle();
    drain_all();

    // Reset while full and draining
    drain_en = 0;
    for (int i = 0; i < 4; i++) begin
      store(32'h200 + 4 * i, 32'hA0 + i, 2'b11);
      cycle();
    end
    idle();
    drain_en = 1;
    cycle();
    rst_n = 0;
    #1;
    chk("t6_rst_wlen", {30'd0, mw_length}, 0);
    cycle();
    rst_n = 1;
    #1;
    chk("t6_ready", {31'd0, st_ready}, 1);
    chk("t6_no_write", {30'd0, mw_length}, 0);
    chk("t6_empty", {31'd0, sb_empty}, 1);
    cycle();
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        store(rand_addr(), $urandom, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) != 0)
        load(rand_addr(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      drain_en = ($urandom_range(0, 3) != 0) || (stall_run >= 2);
      if ($urandom_range(0, 199) == 0) rst_n = 0;
      else rst_n = 1;
      cycle();
    end
    rst_n = 1;
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_store_buffer

`default_nettype wire
